// File: rtl/fifo_param_if.sv
// Producer/consumer-facing bus of fifo_param: write/read requests, data, occupancy and flags.
// The FIFO owns the slave side; the block driving Din/Wen/Ren owns the master side.
interface fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic [WIDTH-1:0] Din;
  logic             Wen;
  logic             Ren;
  logic [WIDTH-1:0] Dout;
  logic             Fempty;
  logic             Ffull;
  logic             Fafull;
  logic             Faempty;
  logic [AW:0]      Count;
  logic             Werr;
  logic             Rerr;

  modport master (
    output Din, Wen, Ren,
    input  Dout, Fempty, Ffull, Fafull, Faempty, Count, Werr, Rerr
  );

  modport slave (
    input  Din, Wen, Ren,
    output Dout, Fempty, Ffull, Fafull, Faempty, Count, Werr, Rerr
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, error pulses and optional FWFT read.
// Flags are registered from next-state occupancy, so they never lag the stored data.
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic         ck,
  input logic         rst,
  fifo_param_if.slave bus
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW + 1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             fempty_q;
  logic             ffull_q;
  logic             fafull_q;
  logic             faempty_q;
  logic             werr_q;
  logic             rerr_q;
  logic             wa;
  logic             ra;

  // A read frees a slot in the same edge, so a write at full is accepted alongside it.
  always_comb begin
    ra      = bus.Ren & ~fempty_q;
    wa      = bus.Wen & (~ffull_q | ra);
    count_d = count_q + {{AW{1'b0}}, wa} - {{AW{1'b0}}, ra};
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      fempty_q  <= 1'b1;
      ffull_q   <= 1'b0;
      fafull_q  <= 1'b0;
      faempty_q <= 1'b1;
      werr_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      if (wa) wptr_q <= wptr_q + 1'b1;
      if (ra) rptr_q <= rptr_q + 1'b1;
      count_q   <= count_d;
      fempty_q  <= (count_d == '0);
      ffull_q   <= (count_d == DEPTH_C);
      fafull_q  <= (count_d >= AF_C);
      faempty_q <= (count_d <= AE_C);
      werr_q    <= bus.Wen & ~wa;
      rerr_q    <= bus.Ren & ~ra;
    end
  end

  // Storage is deliberately not cleared by reset; pointers alone define validity.
  always_ff @(posedge ck) begin
    if (!rst && wa) mem_q[wptr_q] <= bus.Din;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge ck) begin
        if (rst)     dout_q <= '0;
        else if (ra) dout_q <= mem_q[rptr_q];
      end
      assign bus.Dout = dout_q;
    end else begin : g_fwft_read
      assign bus.Dout = mem_q[rptr_q];
    end
  endgenerate

  assign bus.Count   = count_q;
  assign bus.Fempty  = fempty_q;
  assign bus.Ffull   = ffull_q;
  assign bus.Fafull  = fafull_q;
  assign bus.Faempty = faempty_q;
  assign bus.Werr    = werr_q;
  assign bus.Rerr    = rerr_q;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: default registered-read instance plus a 12-bit x 8 FWFT instance.
module tb_fifo_param;
  logic ck = 1'b0;
  logic rst0;
  logic rst1;
  int   checks = 0;
  int   failures = 0;

  always #5 ck = ~ck;

  fifo_param_if #(.WIDTH(8),  .AW(4)) bus0 ();
  fifo_param_if #(.WIDTH(12), .AW(3)) bus1 ();

  fifo_param #(.WIDTH(8), .AW(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut0 (
    .ck  (ck),
    .rst (rst0),
    .bus (bus0.slave)
  );

  fifo_param #(.WIDTH(12), .AW(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_dut1 (
    .ck  (ck),
    .rst (rst1),
    .bus (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.Din = '0; bus0.Wen = 1'b0; bus0.Ren = 1'b0;
    bus1.Din = '0; bus1.Wen = 1'b0; bus1.Ren = 1'b0;
    tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    // reset / idle state
    chk("rst_count",   32'(bus0.Count),   32'd0);
    chk("rst_fempty",  32'(bus0.Fempty),  32'd1);
    chk("rst_ffull",   32'(bus0.Ffull),   32'd0);
    chk("rst_faempty", 32'(bus0.Faempty), 32'd1);
    chk("rst_fafull",  32'(bus0.Fafull),  32'd0);
    chk("rst_werr",    32'(bus0.Werr),    32'd0);
    chk("rst_rerr",    32'(bus0.Rerr),    32'd0);
    chk("rst_dout",    32'(bus0.Dout),    32'd0);

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      bus0.Wen = 1'b1; bus0.Din = 8'(i);
      tick();
      chk("fill_count",   32'(bus0.Count),   32'(i));
      chk("fill_fempty",  32'(bus0.Fempty),  32'd0);
      chk("fill_ffull",   32'(bus0.Ffull),   32'(i == 16));
      chk("fill_fafull",  32'(bus0.Fafull),  32'(i >= 14));
      chk("fill_faempty", 32'(bus0.Faempty), 32'(i <= 2));
    end

    // overflow write while full
    bus0.Din = 8'h11;
    tick();
    chk("ovf_werr",  32'(bus0.Werr),  32'd1);
    chk("ovf_count", 32'(bus0.Count), 32'd16);
    chk("ovf_ffull", 32'(bus0.Ffull), 32'd1);
    chk("ovf_dout",  32'(bus0.Dout),  32'd0);
    bus0.Wen = 1'b0;
    tick();
    chk("ovf_werr_clr", 32'(bus0.Werr), 32'd0);

    // simultaneous read+write at full, 20 cycles, across pointer wrap
    for (int k = 0; k < 20; k++) begin
      bus0.Wen = 1'b1; bus0.Ren = 1'b1; bus0.Din = 8'(8'h20 + k);
      tick();
      chk("rw_dout",  32'(bus0.Dout),  (k < 16) ? 32'(k + 1) : 32'(8'h20 + k - 16));
      chk("rw_count", 32'(bus0.Count), 32'd16);
      chk("rw_ffull", 32'(bus0.Ffull), 32'd1);
      chk("rw_werr",  32'(bus0.Werr),  32'd0);
      chk("rw_rerr",  32'(bus0.Rerr),  32'd0);
    end

    // drain: remaining 0x24..0x33
    bus0.Wen = 1'b0;
    for (int j = 0; j < 16; j++) begin
      bus0.Ren = 1'b1;
      tick();
      chk("drain_dout",    32'(bus0.Dout),    32'(8'h24 + j));
      chk("drain_count",   32'(bus0.Count),   32'(15 - j));
      chk("drain_fempty",  32'(bus0.Fempty),  32'(j == 15));
      chk("drain_faempty", 32'(bus0.Faempty), 32'((15 - j) <= 2));
      chk("drain_fafull",  32'(bus0.Fafull),  32'((15 - j) >= 14));
    end

    // underflow read
    tick();
    chk("unf_rerr",  32'(bus0.Rerr),  32'd1);
    chk("unf_dout",  32'(bus0.Dout),  32'h33);
    chk("unf_count", 32'(bus0.Count), 32'd0);
    bus0.Ren = 1'b0;
    tick();
    chk("unf_rerr_clr", 32'(bus0.Rerr), 32'd0);

    // write+read while empty: write lands, read rejected, no bypass
    bus0.Wen = 1'b1; bus0.Ren = 1'b1; bus0.Din = 8'h5A;
    tick();
    chk("er_count",  32'(bus0.Count),  32'd1);
    chk("er_rerr",   32'(bus0.Rerr),   32'd1);
    chk("er_werr",   32'(bus0.Werr),   32'd0);
    chk("er_dout",   32'(bus0.Dout),   32'h33);
    chk("er_fempty", 32'(bus0.Fempty), 32'd0);
    bus0.Wen = 1'b0;
    tick();
    chk("er_rd_dout",  32'(bus0.Dout),  32'h5A);
    chk("er_rd_count", 32'(bus0.Count), 32'd0);
    chk("er_rd_rerr",  32'(bus0.Rerr),  32'd0);
    bus0.Ren = 1'b0;
    tick();

    // FWFT instance: write-to-read latency of one cycle
    bus1.Wen = 1'b1; bus1.Din = 12'hABC;
    tick();
    chk("fw_dout",   32'(bus1.Dout),   32'hABC);
    chk("fw_count",  32'(bus1.Count),  32'd1);
    chk("fw_fempty", 32'(bus1.Fempty), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      bus1.Din = 12'(i * 12'h111);
      tick();
    end
    bus1.Wen = 1'b0;
    chk("fw_count5",  32'(bus1.Count),  32'd5);
    chk("fw_hold",    32'(bus1.Dout),   32'hABC);
    chk("fw_fafull5", 32'(bus1.Fafull), 32'd0);
    bus1.Ren = 1'b1;
    tick();
    bus1.Ren = 1'b0;
    chk("fw_pop_dout",  32'(bus1.Dout),  32'h111);
    chk("fw_pop_count", 32'(bus1.Count), 32'd4);
    bus1.Wen = 1'b1; bus1.Din = 12'h555;
    tick();
    bus1.Wen = 1'b0;
    chk("fw_count5b", 32'(bus1.Count), 32'd5);

    // reset at Count=5 with a write request that must be ignored
    rst1 = 1'b1; bus1.Wen = 1'b1; bus1.Din = 12'h999;
    tick();
    rst1 = 1'b0; bus1.Wen = 1'b0;
    chk("fw_rst_count",   32'(bus1.Count),   32'd0);
    chk("fw_rst_fempty",  32'(bus1.Fempty),  32'd1);
    chk("fw_rst_faempty", 32'(bus1.Faempty), 32'd1);
    chk("fw_rst_werr",    32'(bus1.Werr),    32'd0);
    tick();
    chk("fw_rst_count2",  32'(bus1.Count),   32'd0);

    bus1.Wen = 1'b1; bus1.Din = 12'h7E5;
    tick();
    bus1.Wen = 1'b0;
    chk("fw_new_dout",  32'(bus1.Dout),  32'h7E5);
    chk("fw_new_count", 32'(bus1.Count), 32'd1);
    bus1.Ren = 1'b1;
    tick();
    bus1.Ren = 1'b0;
    chk("fw_new_count0", 32'(bus1.Count),  32'd0);
    chk("fw_new_fempty", 32'(bus1.Fempty), 32'd1);
    chk("fw_new_rerr",   32'(bus1.Rerr),   32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
